hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core; sits beside the decode stage and drives the PC, IF/ID and pipeline-freeze enables, plus the decode-stage control-zeroing select (control_sel).
- Resolves three hazard classes: data-memory wait, taken branch/jump flush, and load-use.
- Keeps saturating performance counters and a sticky memory-timeout error flag.

Parameters:
- FLUSH_CYCLES, 1, cycles flush/bubble held per taken branch (≥1)
- MEM_TIMEOUT, 15, max cycles in MEM_WAIT before abandon (≥1)
- CNT_W, 32, width of stall_count and flush_count

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- MemRead_EX  in  1  instruction in EX is a load
- RD_EX  in  5  destination register of the instruction in EX
- RS1_ID  in  5  rs1 of the instruction in ID
- RS2_ID  in  5  rs2 of the instruction in ID
- OPCODE_ID  in  7  opcode of the instruction in ID
- branch_taken_EX  in  1  branch/jump in EX resolved taken
- mem_access_MEM  in  1  load or store active in MEM
- mem_ready  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC register enable
- IF_IDWrite  out  1  IF/ID register enable
- flush_IF_ID  out  1  clear IF/ID to NOP
- control_sel  out  1  1 = zero ID control signals (bubble into ID/EX)
- pipe_stall  out  1  freeze ID/EX, EX/MEM and MEM/WB
- stall_count  out  CNT_W  cycles with PCWrite=0
- flush_count  out  CNT_W  taken branches accepted
- mem_err  out  1  sticky: a memory access timed out

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs forced: PCWrite=0, IF_IDWrite=0, flush_IF_ID=1, control_sel=1, pipe_stall=0.
  - State=RUN; flush counter, wait counter, stall_count, flush_count and mem_err all cleared to 0; ret_state=RUN.
  - Reset mid-wait or mid-flush aborts that operation.
- Outputs are combinational from state and inputs (Mealy). Counters and state are registered.
- Register-usage decode from OPCODE_ID:
  - 0110011, 0100011, 1100011 use rs1 and rs2.
  - 0010011, 0000011, 1100111 use rs1 only.
  - All other opcodes use neither.
- load_use = MemRead_EX & (RD_EX != 0) & ((uses_rs1 & RD_EX == RS1_ID) | (uses_rs2 & RD_EX == RS2_ID)).
- mem_hold = mem_access_MEM & !mem_ready.
- RUN, conditions checked in priority order:
  - mem_hold: PCWrite=0, IF_IDWrite=0, pipe_stall=1, control_sel=0, flush_IF_ID=0. Set ret_state=RUN, wait counter=1, go to MEM_WAIT.
  - branch_taken_EX: PCWrite=1, IF_IDWrite=1, flush_IF_ID=1, control_sel=1; flush_count+1. If FLUSH_CYCLES>1, load flush counter with FLUSH_CYCLES-1 and go to FLUSH; else stay in RUN.
  - load_use: PCWrite=0, IF_IDWrite=0, control_sel=1, others 0. Exactly one bubble; stay in RUN.
  - Otherwise: PCWrite=1, IF_IDWrite=1, all other outputs 0.
- FLUSH:
  - Normally: flush_IF_ID=1, control_sel=1, PCWrite=1, IF_IDWrite=1. Decrement the flush counter; go to RUN when it reaches 0.
  - mem_hold has priority: MEM_WAIT outputs, flush counter preserved, ret_state=FLUSH. A new branch_taken_EX in FLUSH is ignored (its instruction is already being flushed).
- MEM_WAIT:
  - While mem_ready=0: freeze outputs (as the RUN mem_hold case); wait counter +1 per cycle.
  - mem_ready=1: outputs and next state evaluated exactly as ret_state, with mem_hold treated as false; wait counter cleared.
  - Wait counter reaches MEM_TIMEOUT with no ready: set mem_err=1 (sticky until reset), clear wait counter, return to ret_state next cycle.
- stall_count increments in every cycle PCWrite=0 outside reset. Both counters saturate at all-ones (no wrap).
- x0 never triggers load_use. A taken branch in the same cycle as load_use is resolved as the branch only; no stall is counted.

Test Plan:
- Load-use: lw x5 in EX (MemRead_EX=1, RD_EX=5), ID add x6,x5,x7 (OPCODE 0110011, RS1=5) -> one cycle PCWrite=0, IF_IDWrite=0, control_sel=1; stall_count 0->1; next cycle normal.
- x0 and unused-rs cases: RD_EX=0, RS1_ID=0 -> no stall. RD_EX=5 with ID lui (0110111, RS1 field=5) -> no stall.
- Branch flush, FLUSH_CYCLES=3: branch_taken_EX pulse -> flush_IF_ID=1 and control_sel=1 for 3 consecutive cycles; flush_count=1. Same cycle with load_use -> no stall, stall_count unchanged.
- Memory wait: mem_access_MEM=1, mem_ready=0 for 4 cycles then 1 -> pipe_stall=1 and PCWrite=0 for 4 cycles, released on the ready cycle; stall_count=4; mem_err=0.
- Timeout, MEM_TIMEOUT=15: mem_ready held 0 -> mem_err=1 after 15 wait cycles, state returns to RUN; mem_err stays 1 until rst_n=0.
- Mid-operation reset: assert rst_n=0 during FLUSH (FLUSH_CYCLES=3, 2nd cycle) -> outputs take reset values immediately; after release, RUN and counters 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: hazard inputs from ID/EX/MEM
// and the enables, bubble/flush selects and status it returns to the core.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             MemRead_EX;
  logic [4:0]       RD_EX;
  logic [4:0]       RS1_ID;
  logic [4:0]       RS2_ID;
  logic [6:0]       OPCODE_ID;
  logic             branch_taken_EX;
  logic             mem_access_MEM;
  logic             mem_ready;
  logic             PCWrite;
  logic             IF_IDWrite;
  logic             flush_IF_ID;
  logic             control_sel;
  logic             pipe_stall;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_err;

  // Core side: drives hazard sources, consumes the control outputs.
  modport master (
    output MemRead_EX, RD_EX, RS1_ID, RS2_ID, OPCODE_ID,
           branch_taken_EX, mem_access_MEM, mem_ready,
    input  PCWrite, IF_IDWrite, flush_IF_ID, control_sel, pipe_stall,
           stall_count, flush_count, mem_err
  );

  modport slave (
    input  MemRead_EX, RD_EX, RS1_ID, RS2_ID, OPCODE_ID,
           branch_taken_EX, mem_access_MEM, mem_ready,
    output PCWrite, IF_IDWrite, flush_IF_ID, control_sel, pipe_stall,
           stall_count, flush_count, mem_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard sequencing for the 5-stage RV32I pipeline: memory-wait freeze, taken-branch
// flush and load-use bubble, with saturating stall/flush counters and a timeout flag.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [WW:0]   TIMEOUT    = (WW+1)'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_FREEZE = 2'd3
  } act_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             mem_err_q, mem_err_d;

  logic uses_rs1, uses_rs2, load_use, mem_hold;
  act_t act;
  logic pc_write, ifid_write, flush_ifid, ctrl_sel, pipe_stall;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (hz.OPCODE_ID)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = hz.MemRead_EX && (hz.RD_EX != 5'd0) &&
                    ((uses_rs1 && (hz.RD_EX == hz.RS1_ID)) ||
                     (uses_rs2 && (hz.RD_EX == hz.RS2_ID)));
  assign mem_hold = hz.mem_access_MEM && !hz.mem_ready;

  always_comb begin
    state_t     eff_state;
    logic       eff_hold;
    logic       serve;
    logic [WW:0] wait_inc;

    act           = ACT_RUN;
    state_d       = state_q;
    ret_d         = ret_q;
    flush_d       = flush_q;
    wait_d        = wait_q;
    mem_err_d     = mem_err_q;
    flush_count_d = flush_count_q;
    eff_state     = state_q;
    eff_hold      = mem_hold;
    serve         = 1'b1;
    wait_inc      = {1'b0, wait_q} + (WW+1)'(1);

    // A completed access resumes whatever was interrupted, as if no wait had occurred.
    if (state_q == ST_MEM_WAIT) begin
      if (!hz.mem_ready) begin
        serve = 1'b0;
        act   = ACT_FREEZE;
        if (wait_inc >= TIMEOUT) begin
          mem_err_d = 1'b1;
          wait_d    = '0;
          state_d   = ret_q;
        end else begin
          wait_d = wait_inc[WW-1:0];
        end
      end else begin
        wait_d    = '0;
        eff_state = ret_q;
        eff_hold  = 1'b0;
      end
    end

    if (serve) begin
      if (eff_hold) begin
        act     = ACT_FREEZE;
        ret_d   = (eff_state == ST_FLUSH) ? ST_FLUSH : ST_RUN;
        wait_d  = WW'(1);
        state_d = ST_MEM_WAIT;
      end else if (eff_state == ST_FLUSH) begin
        // Branches seen here are already on the wrong path and are ignored.
        act     = ACT_FLUSH;
        flush_d = flush_q - FW'(1);
        state_d = (flush_d == '0) ? ST_RUN : ST_FLUSH;
      end else if (hz.branch_taken_EX) begin
        act = ACT_FLUSH;
        if (!(&flush_count_q)) flush_count_d = flush_count_q + CNT_W'(1);
        if (FLUSH_CYCLES > 1) begin
          flush_d = FLUSH_LOAD;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end else if (load_use) begin
        act     = ACT_BUBBLE;
        state_d = ST_RUN;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    flush_ifid = 1'b0;
    ctrl_sel   = 1'b0;
    pipe_stall = 1'b0;
    case (act)
      ACT_BUBBLE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ctrl_sel   = 1'b1;
      end
      ACT_FLUSH: begin
        flush_ifid = 1'b1;
        ctrl_sel   = 1'b1;
      end
      ACT_FREEZE: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_stall = 1'b1;
      end
      default: ;
    endcase
    // Reset holds the front end closed and injects NOPs regardless of state.
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush_ifid = 1'b1;
      ctrl_sel   = 1'b1;
      pipe_stall = 1'b0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write && !(&stall_count_q)) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      ret_q         <= ST_RUN;
      flush_q       <= '0;
      wait_q        <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      flush_q       <= flush_d;
      wait_q        <= wait_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign hz.PCWrite     = pc_write;
  assign hz.IF_IDWrite  = ifid_write;
  assign hz.flush_IF_ID = flush_ifid;
  assign hz.control_sel = ctrl_sel;
  assign hz.pipe_stall  = pipe_stall;
  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;
  assign hz.mem_err     = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: single-cycle decode table, directed multi-cycle sequences and a
// long random run checked against a cycle-level behavioural model.
module tb_hazard_ctrl;
  localparam int FC   = 3;
  localparam int TO   = 15;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  // {PCWrite, IF_IDWrite, flush_IF_ID, control_sel, pipe_stall}
  localparam logic [4:0] O_RUN = 5'b11000;
  localparam logic [4:0] O_BUB = 5'b00010;
  localparam logic [4:0] O_FLU = 5'b11110;
  localparam logic [4:0] O_FRZ = 5'b00001;
  localparam logic [4:0] O_RST = 5'b00110;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: owed flush cycles, outstanding wait and its length so far, status.
  int m_pending, m_wlen, m_stalls, m_flushes;
  bit m_wait, m_err;
  logic [4:0] last_out;

  typedef struct {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] op;
    logic       br;
    logic       acc;
    logic       rdy;
    logic [4:0] exp_out;
  } vec_t;

  vec_t tbl [15];
  logic [6:0] ops [8];

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  function automatic bit model_load_use();
    bit r1, r2;
    r1 = hz.OPCODE_ID inside {7'b0110011, 7'b0100011, 7'b1100011,
                              7'b0010011, 7'b0000011, 7'b1100111};
    r2 = hz.OPCODE_ID inside {7'b0110011, 7'b0100011, 7'b1100011};
    return hz.MemRead_EX && (hz.RD_EX != 0) &&
           ((r1 && hz.RD_EX == hz.RS1_ID) || (r2 && hz.RD_EX == hz.RS2_ID));
  endfunction

  function automatic logic [4:0] dut_out();
    return {hz.PCWrite, hz.IF_IDWrite, hz.flush_IF_ID, hz.control_sel, hz.pipe_stall};
  endfunction

  task automatic model_reset();
    m_pending = 0; m_wlen = 0; m_stalls = 0; m_flushes = 0; m_wait = 0; m_err = 0;
  endtask

  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [6:0] op, input logic br,
                        input logic acc, input logic rdy);
    hz.MemRead_EX = mr; hz.RD_EX = rd; hz.RS1_ID = rs1; hz.RS2_ID = rs2;
    hz.OPCODE_ID = op; hz.branch_taken_EX = br; hz.mem_access_MEM = acc; hz.mem_ready = rdy;
  endtask

  task automatic set_idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 7'b0010011, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: predict from the model, compare mid-cycle, advance the model at the edge.
  task automatic step(input string name);
    logic [4:0] e_out, g_out;
    int n_pending, n_wlen, n_stalls, n_flushes;
    bit n_wait, n_err, hold, lu, freeze;
    hold = hz.mem_access_MEM && !hz.mem_ready;
    lu = model_load_use();
    n_pending = m_pending; n_wlen = m_wlen; n_stalls = m_stalls;
    n_flushes = m_flushes; n_wait = m_wait; n_err = m_err;
    freeze = m_wait ? !hz.mem_ready : hold;
    if (freeze) begin
      e_out = O_FRZ;
      if (m_wait) begin
        n_wlen = m_wlen + 1;
        if (n_wlen >= TO) begin
          n_err = 1; n_wait = 0; n_wlen = 0;
        end
      end else begin
        n_wait = 1; n_wlen = 1;
      end
    end else begin
      n_wait = 0; n_wlen = 0;
      if (m_pending > 0) begin
        e_out = O_FLU; n_pending = m_pending - 1;
      end else if (hz.branch_taken_EX) begin
        e_out = O_FLU; n_flushes = sat(m_flushes + 1); n_pending = FC - 1;
      end else if (lu) e_out = O_BUB;
      else e_out = O_RUN;
    end
    if (e_out[4] == 1'b0) n_stalls = sat(m_stalls + 1);
    #3;
    g_out = dut_out();
    last_out = g_out;
    vectors++;
    if (g_out !== e_out || hz.stall_count !== CW'(m_stalls) ||
        hz.flush_count !== CW'(m_flushes) || hz.mem_err !== logic'(m_err)) begin
      miscompares++;
      $display("FAIL %s: got outs=%b sc=%0d fc=%0d err=%b, required outs=%b sc=%0d fc=%0d err=%b",
               name, g_out, hz.stall_count, hz.flush_count, hz.mem_err,
               e_out, m_stalls, m_flushes, m_err);
    end
    @(posedge clk);
    m_pending = n_pending; m_wlen = n_wlen; m_stalls = n_stalls;
    m_flushes = n_flushes; m_wait = n_wait; m_err = n_err;
    #1;
  endtask

  initial begin
    int cnt;
    //          mr    rd     rs1    rs2    op          br    acc   rdy   expected
    tbl[0]  = '{1'b1, 5'd5,  5'd5,  5'd7,  7'b0110011, 1'b0, 1'b0, 1'b0, O_BUB};
    tbl[1]  = '{1'b1, 5'd0,  5'd0,  5'd0,  7'b0110011, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[2]  = '{1'b1, 5'd5,  5'd5,  5'd0,  7'b0110111, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[3]  = '{1'b1, 5'd9,  5'd1,  5'd9,  7'b0110011, 1'b0, 1'b0, 1'b0, O_BUB};
    tbl[4]  = '{1'b1, 5'd12, 5'd3,  5'd12, 7'b0100011, 1'b0, 1'b0, 1'b0, O_BUB};
    tbl[5]  = '{1'b1, 5'd4,  5'd4,  5'd8,  7'b1100011, 1'b0, 1'b0, 1'b0, O_BUB};
    tbl[6]  = '{1'b1, 5'd6,  5'd2,  5'd6,  7'b0010011, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[7]  = '{1'b1, 5'd7,  5'd7,  5'd1,  7'b0000011, 1'b0, 1'b0, 1'b0, O_BUB};
    tbl[8]  = '{1'b1, 5'd1,  5'd1,  5'd0,  7'b1100111, 1'b0, 1'b0, 1'b0, O_BUB};
    tbl[9]  = '{1'b1, 5'd1,  5'd1,  5'd1,  7'b1101111, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[10] = '{1'b0, 5'd5,  5'd5,  5'd5,  7'b0110011, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[11] = '{1'b1, 5'd5,  5'd5,  5'd7,  7'b0110011, 1'b1, 1'b0, 1'b0, O_FLU};
    tbl[12] = '{1'b1, 5'd5,  5'd5,  5'd7,  7'b0110011, 1'b1, 1'b1, 1'b0, O_FRZ};
    tbl[13] = '{1'b1, 5'd5,  5'd5,  5'd7,  7'b0110011, 1'b0, 1'b1, 1'b1, O_BUB};
    tbl[14] = '{1'b1, 5'd31, 5'd31, 5'd0,  7'b0010011, 1'b0, 1'b0, 1'b0, O_BUB};
    ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011,
            7'b0000011, 7'b1100111, 7'b0110111, 7'b1101111};

    // Reset state
    rst_n = 1'b0;
    set_idle();
    model_reset();
    #2;
    check("reset_outs", 32'(dut_out()), 32'(O_RST));
    check("reset_stall_count", 32'(hz.stall_count), 32'd0);
    check("reset_flush_count", 32'(hz.flush_count), 32'd0);
    check("reset_mem_err", 32'(hz.mem_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-cycle decode table, each vector from a fresh RUN state
    for (int i = 0; i < 15; i++) begin
      apply_reset();
      set_in(tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].op,
             tbl[i].br, tbl[i].acc, tbl[i].rdy);
      #3;
      vectors++;
      if (dut_out() !== tbl[i].exp_out) begin
        miscompares++;
        $display("FAIL table[%0d]: got outs=%b, required outs=%b", i, dut_out(), tbl[i].exp_out);
      end
    end

    // Load-use: exactly one bubble
    apply_reset();
    set_in(1'b1, 5'd5, 5'd5, 5'd7, 7'b0110011, 1'b0, 1'b0, 1'b0);
    step("lu_bubble");
    set_idle();
    step("lu_release");
    check("lu_stall_count", 32'(hz.stall_count), 32'd1);

    // Branch flush with simultaneous load-use; later branch/load-use ignored during flush
    apply_reset();
    cnt = 0;
    set_in(1'b1, 5'd5, 5'd5, 5'd7, 7'b0110011, 1'b1, 1'b0, 1'b0);
    step("br_take");
    cnt += int'(last_out[2]);
    for (int k = 0; k < 2; k++) begin
      step("br_flush");
      cnt += int'(last_out[2]);
    end
    set_idle();
    step("br_after");
    cnt += int'(last_out[2]);
    check("br_flush_cycles", 32'(cnt), 32'd3);
    check("br_flush_count", 32'(hz.flush_count), 32'd1);
    check("br_stall_count", 32'(hz.stall_count), 32'd0);

    // Memory wait of four cycles, released on ready
    apply_reset();
    cnt = 0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 7'b0000011, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step("mw_hold");
      cnt += int'(last_out[0]);
    end
    hz.mem_ready = 1'b1;
    step("mw_ready");
    cnt += int'(last_out[0]);
    check("mw_stall_cycles", 32'(cnt), 32'd4);
    check("mw_stall_count", 32'(hz.stall_count), 32'd4);
    check("mw_mem_err", 32'(hz.mem_err), 32'd0);

    // Timeout: error appears after the 15th wait cycle and is sticky
    apply_reset();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 7'b0000011, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < TO - 1; k++) step("to_wait");
    check("to_err_before", 32'(hz.mem_err), 32'd0);
    step("to_last");
    check("to_err_set", 32'(hz.mem_err), 32'd1);
    set_idle();
    for (int k = 0; k < 5; k++) step("to_run");
    check("to_err_sticky", 32'(hz.mem_err), 32'd1);
    apply_reset();
    check("to_err_cleared", 32'(hz.mem_err), 32'd0);

    // Wait inside a flush resumes the flush afterwards
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 7'b1100011, 1'b1, 1'b0, 1'b0);
    step("fw_branch");
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 7'b1100011, 1'b1, 1'b1, 1'b0);
    step("fw_hold");
    step("fw_wait");
    hz.mem_ready = 1'b1;
    step("fw_ready");
    set_idle();
    step("fw_flush");
    step("fw_run");

    // Reset in the second flush cycle
    apply_reset();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 7'b1100011, 1'b1, 1'b0, 1'b0);
    step("mf_branch");
    set_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("mf_reset_outs", 32'(dut_out()), 32'(O_RST));
    check("mf_reset_flush_count", 32'(hz.flush_count), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("mf_after");
    step("mf_after2");

    // Randomized run; alternating phases of slow memory force timeouts
    apply_reset();
    for (int n = 0; n < 4000; n++) begin
      logic slow;
      if ($urandom_range(0, 299) == 0) apply_reset();
      slow = ((n / 400) % 2) == 1;
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ops[$urandom_range(0, 7)],
             1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
             slow ? 1'($urandom_range(0, 19) == 0) : 1'($urandom_range(0, 1)));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
